load_inst_encoder: RTL and testbench

Builds 128-bit VTA LOAD instructions for the load queue from a tile descriptor. It is the encoder counterpart of the load-side instruction decode. Tiles taller than `MAX_Y` rows are split into several back-to-back instructions, with SRAM and DRAM offsets advanced per chunk. A descriptor with `xsize == 0` produces a single sync (dependency-only) instruction.

---
 rtl/load_inst_encoder.sv | 159 +++++++++++++++
 tb/tb_load_inst_encoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_inst_encoder.sv
// Encodes tile descriptors into 128-bit VTA LOAD instructions, splitting tall
// tiles into MAX_Y-row chunks with SRAM/DRAM offsets advanced per chunk.
module load_inst_encoder #(
  parameter int MAX_Y = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         io_desc_valid,
  output logic         io_desc_ready,
  input  logic [2:0]   io_desc_id,
  input  logic [15:0]  io_desc_sram,
  input  logic [31:0]  io_desc_dram,
  input  logic [15:0]  io_desc_ysize,
  input  logic [15:0]  io_desc_xsize,
  input  logic [15:0]  io_desc_xstride,
  input  logic [3:0]   io_desc_ypad0,
  input  logic [3:0]   io_desc_ypad1,
  input  logic [3:0]   io_desc_xpad0,
  input  logic [3:0]   io_desc_xpad1,
  input  logic         io_desc_pop_prev,
  input  logic         io_desc_pop_next,
  input  logic         io_desc_push_prev,
  input  logic         io_desc_push_next,
  output logic         io_inst_valid,
  input  logic         io_inst_ready,
  output logic [127:0] io_inst,
  output logic         io_busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam logic [15:0] MAX_Y_W = 16'(MAX_Y);

  logic [0:0]   state;
  logic [127:0] inst_q;
  logic         valid_q, last_q;
  logic [15:0]  rem_q, sram_q;
  logic [31:0]  dram_q;
  logic [2:0]   d_id;
  logic [15:0]  d_ysize, d_xsize, d_xstride;
  logic [3:0]   d_ypad0, d_ypad1, d_xpad0, d_xpad1;
  logic [3:0]   d_flags;

  logic         s_first;
  logic [15:0]  s_rem, s_sram, s_ysize, s_xsize, s_xstride;
  logic [31:0]  s_dram;
  logic [2:0]   s_id;
  logic [3:0]   s_ypad0, s_ypad1, s_xpad0, s_xpad1, s_flags;

  logic [15:0]  c, rows, pitch, sram_step, ysz;
  logic [31:0]  dram_step;
  logic         is_last;
  logic [3:0]   o_ypad0, o_ypad1;
  logic [127:0] chunk;

  logic accept, inst_fire;
  assign accept    = (state == IDLE) && io_desc_valid;
  assign inst_fire = (state == EMIT) && valid_q && io_inst_ready;

  // Chunk source: live descriptor when accepting, latched copy when advancing.
  always_comb begin
    if (state == IDLE) begin
      s_first   = 1'b1;
      s_rem     = io_desc_ysize;
      s_sram    = io_desc_sram;
      s_dram    = io_desc_dram;
      s_id      = io_desc_id;
      s_ysize   = io_desc_ysize;
      s_xsize   = io_desc_xsize;
      s_xstride = io_desc_xstride;
      s_ypad0   = io_desc_ypad0;
      s_ypad1   = io_desc_ypad1;
      s_xpad0   = io_desc_xpad0;
      s_xpad1   = io_desc_xpad1;
      s_flags   = {io_desc_push_next, io_desc_push_prev, io_desc_pop_next, io_desc_pop_prev};
    end else begin
      s_first   = 1'b0;
      s_rem     = rem_q;
      s_sram    = sram_q;
      s_dram    = dram_q;
      s_id      = d_id;
      s_ysize   = d_ysize;
      s_xsize   = d_xsize;
      s_xstride = d_xstride;
      s_ypad0   = d_ypad0;
      s_ypad1   = d_ypad1;
      s_xpad0   = d_xpad0;
      s_xpad1   = d_xpad1;
      s_flags   = d_flags;
    end
  end

  assign c       = (s_rem > MAX_Y_W) ? MAX_Y_W : s_rem;
  assign is_last = (s_xsize == 16'd0) || (s_rem <= MAX_Y_W);
  assign ysz     = (s_xsize == 16'd0) ? s_ysize : c;
  assign o_ypad0 = s_first ? s_ypad0 : 4'd0;
  assign o_ypad1 = is_last ? s_ypad1 : 4'd0;

  // Only the low 16/32 bits of each product survive the wrap, so operands
  // truncated to the result width give the same answer as full-width math.
  assign rows      = c + {12'd0, o_ypad0};
  assign pitch     = s_xsize + {12'd0, s_xpad0} + {12'd0, s_xpad1};
  assign sram_step = rows * pitch;
  assign dram_step = 32'(c) * 32'(s_xstride);

  assign chunk = {s_xpad1, s_xpad0, o_ypad1, o_ypad0, s_xstride, s_xsize, ysz,
                  6'd0, s_dram, s_sram, s_id,
                  s_flags[3] & is_last, s_flags[2] & is_last,
                  s_flags[1] & s_first, s_flags[0] & s_first, 3'd0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      inst_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      rem_q     <= '0;
      sram_q    <= '0;
      dram_q    <= '0;
      d_id      <= '0;
      d_ysize   <= '0;
      d_xsize   <= '0;
      d_xstride <= '0;
      d_ypad0   <= '0;
      d_ypad1   <= '0;
      d_xpad0   <= '0;
      d_xpad1   <= '0;
      d_flags   <= '0;
    end else if (accept || (inst_fire && !last_q)) begin
      if (accept) begin
        d_id      <= io_desc_id;
        d_ysize   <= io_desc_ysize;
        d_xsize   <= io_desc_xsize;
        d_xstride <= io_desc_xstride;
        d_ypad0   <= io_desc_ypad0;
        d_ypad1   <= io_desc_ypad1;
        d_xpad0   <= io_desc_xpad0;
        d_xpad1   <= io_desc_xpad1;
        d_flags   <= s_flags;
      end
      state   <= EMIT;
      inst_q  <= chunk;
      valid_q <= 1'b1;
      last_q  <= is_last;
      rem_q   <= s_rem - c;
      sram_q  <= s_sram + sram_step;
      dram_q  <= s_dram + dram_step;
    end else if (inst_fire) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end
  end

  assign io_inst       = inst_q;
  assign io_inst_valid = valid_q;
  assign io_desc_ready = (state == IDLE);
  assign io_busy       = (state != IDLE);

endmodule

// File: tb/tb_load_inst_encoder.sv
// Directed and randomized checks of load_inst_encoder against a row-by-row
// reference model of the chunking rules.
module tb_load_inst_encoder;

  localparam int MAX_Y = 64;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         io_desc_valid, io_desc_ready;
  logic [2:0]   io_desc_id;
  logic [15:0]  io_desc_sram, io_desc_ysize, io_desc_xsize, io_desc_xstride;
  logic [31:0]  io_desc_dram;
  logic [3:0]   io_desc_ypad0, io_desc_ypad1, io_desc_xpad0, io_desc_xpad1;
  logic         io_desc_pop_prev, io_desc_pop_next, io_desc_push_prev, io_desc_push_next;
  logic         io_inst_valid, io_inst_ready, io_busy;
  logic [127:0] io_inst;

  load_inst_encoder #(.MAX_Y(MAX_Y)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_desc_valid(io_desc_valid), .io_desc_ready(io_desc_ready),
    .io_desc_id(io_desc_id), .io_desc_sram(io_desc_sram), .io_desc_dram(io_desc_dram),
    .io_desc_ysize(io_desc_ysize), .io_desc_xsize(io_desc_xsize),
    .io_desc_xstride(io_desc_xstride),
    .io_desc_ypad0(io_desc_ypad0), .io_desc_ypad1(io_desc_ypad1),
    .io_desc_xpad0(io_desc_xpad0), .io_desc_xpad1(io_desc_xpad1),
    .io_desc_pop_prev(io_desc_pop_prev), .io_desc_pop_next(io_desc_pop_next),
    .io_desc_push_prev(io_desc_push_prev), .io_desc_push_next(io_desc_push_next),
    .io_inst_valid(io_inst_valid), .io_inst_ready(io_inst_ready),
    .io_inst(io_inst), .io_busy(io_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] sram;
    logic [31:0] dram;
    logic [15:0] ysize, xsize, xstride;
    logic [3:0]  ypad0, ypad1, xpad0, xpad1;
    logic        pop_prev, pop_next, push_prev, push_next;
  } desc_t;

  int checks = 0;
  int errors = 0;
  logic [127:0] expq[$];
  logic [127:0] got_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic pp, pn, hp, hn, input logic [2:0] id,
      input logic [15:0] sram, input logic [31:0] dram, input logic [15:0] ys, xs, xst,
      input logic [3:0] yp0, yp1, xp0, xp1);
    return {xp1, xp0, yp1, yp0, xst, xs, ys, 6'd0, dram, sram, id, hn, hp, pn, pp, 3'd0};
  endfunction

  // Reference: walk the tile, peeling off up to MAX_Y rows per instruction.
  task automatic build_expected(input desc_t d);
    longint rem, c, s, dr, pitch, padrows;
    bit first, last;
    logic [15:0] s16, c16;
    logic [31:0] d32;
    expq.delete();
    if (d.xsize == 0) begin
      expq.push_back(pack(d.pop_prev, d.pop_next, d.push_prev, d.push_next, d.id, d.sram,
                          d.dram, d.ysize, d.xsize, d.xstride, d.ypad0, d.ypad1, d.xpad0, d.xpad1));
      return;
    end
    rem = d.ysize; s = d.sram; dr = d.dram; first = 1;
    pitch = longint'(d.xpad0) + longint'(d.xsize) + longint'(d.xpad1);
    do begin
      c = (rem > MAX_Y) ? MAX_Y : rem;
      last = (rem == c);
      s16 = s[15:0]; d32 = dr[31:0]; c16 = c[15:0];
      expq.push_back(pack(first & d.pop_prev, first & d.pop_next, last & d.push_prev,
                          last & d.push_next, d.id, s16, d32, c16, d.xsize, d.xstride,
                          first ? d.ypad0 : 4'd0, last ? d.ypad1 : 4'd0, d.xpad0, d.xpad1));
      padrows = first ? longint'(d.ypad0) : 0;
      s  = (s + (c + padrows) * pitch) % 65536;
      dr = (dr + c * longint'(d.xstride)) % 64'h1_0000_0000;
      rem -= c;
      first = 0;
    end while (rem != 0);
  endtask

  task automatic drive_desc(input desc_t d);
    io_desc_id = d.id; io_desc_sram = d.sram; io_desc_dram = d.dram;
    io_desc_ysize = d.ysize; io_desc_xsize = d.xsize; io_desc_xstride = d.xstride;
    io_desc_ypad0 = d.ypad0; io_desc_ypad1 = d.ypad1;
    io_desc_xpad0 = d.xpad0; io_desc_xpad1 = d.xpad1;
    io_desc_pop_prev = d.pop_prev; io_desc_pop_next = d.pop_next;
    io_desc_push_prev = d.push_prev; io_desc_push_next = d.push_next;
  endtask

  task automatic run(input desc_t d, input bit bp, input string tag);
    int idx, cyc;
    build_expected(d);
    got_q.delete();
    @(negedge clock);
    drive_desc(d);
    io_desc_valid = 1'b1;
    io_inst_ready = 1'b0;
    check({tag, " desc_ready_idle"}, 128'(io_desc_ready), 128'd1);
    @(posedge clock);
    idx = 0; cyc = 0;
    while (idx < expq.size() && cyc < 4000) begin
      @(negedge clock);
      check({tag, " valid"}, 128'(io_inst_valid), 128'd1);
      check({tag, " desc_ready_busy"}, 128'(io_desc_ready), 128'd0);
      check({tag, " busy"}, 128'(io_busy), 128'd1);
      check($sformatf("%s inst%0d", tag, idx), io_inst, expq[idx]);
      // Scramble descriptor inputs; the encoder must work from its latched copy.
      io_desc_sram = 16'($urandom); io_desc_dram = $urandom;
      io_desc_ysize = 16'($urandom); io_desc_xsize = 16'($urandom);
      io_inst_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (io_inst_ready) begin
        got_q.push_back(io_inst);
        idx++;
      end
      @(posedge clock);
      cyc++;
    end
    check({tag, " count"}, 128'(idx), 128'(expq.size()));
    if (!bp) check({tag, " cycles"}, 128'(cyc), 128'(expq.size()));
    @(negedge clock);
    io_desc_valid = 1'b0;
    io_inst_ready = 1'b0;
    check({tag, " end_valid"}, 128'(io_inst_valid), 128'd0);
    check({tag, " end_desc_ready"}, 128'(io_desc_ready), 128'd1);
    check({tag, " end_busy"}, 128'(io_busy), 128'd0);
  endtask

  function automatic desc_t zero_desc();
    desc_t d;
    d.id = 0; d.sram = 0; d.dram = 0; d.ysize = 0; d.xsize = 0; d.xstride = 0;
    d.ypad0 = 0; d.ypad1 = 0; d.xpad0 = 0; d.xpad1 = 0;
    d.pop_prev = 0; d.pop_next = 0; d.push_prev = 0; d.push_next = 0;
    return d;
  endfunction

  initial begin
    desc_t d, split;
    int stray;
    reset_n = 1'b0;
    io_desc_valid = 1'b0;
    io_inst_ready = 1'b0;
    drive_desc(zero_desc());
    #1;
    check("reset valid", 128'(io_inst_valid), 128'd0);
    check("reset inst", io_inst, 128'd0);
    check("reset desc_ready", 128'(io_desc_ready), 128'd1);
    check("reset busy", 128'(io_busy), 128'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Sync instruction
    d = zero_desc(); d.id = 2; d.push_next = 1;
    run(d, 0, "sync");
    check("sync value", got_q.size() > 0 ? got_q[0] : 128'hx, 128'h140);

    // Single chunk, exact fit
    d = zero_desc(); d.id = 1; d.ysize = 64; d.xsize = 16; d.sram = 16'h20; d.dram = 32'h400;
    d.pop_next = 1; d.push_next = 1;
    run(d, 0, "exact");
    check("exact n", 128'(got_q.size()), 128'd1);

    // Split tile into three chunks
    split = zero_desc(); split.ysize = 150; split.xsize = 16; split.xstride = 32;
    split.sram = 16'h100; split.dram = 32'h1000; split.ypad0 = 1; split.ypad1 = 2;
    split.pop_prev = 1; split.push_next = 1;
    run(split, 0, "split");
    if (got_q.size() == 3) begin
      check("split c1 sram", 128'(got_q[1][25:10]), 128'h510);
      check("split c1 dram", 128'(got_q[1][57:26]), 128'h1800);
      check("split c2 sram", 128'(got_q[2][25:10]), 128'h910);
      check("split c2 dram", 128'(got_q[2][57:26]), 128'h2000);
      check("split c2 ysize", 128'(got_q[2][79:64]), 128'd22);
      check("split c2 ypad1", 128'(got_q[2][119:116]), 128'd2);
    end else check("split n", 128'(got_q.size()), 128'd3);

    run(split, 1, "backpressure");

    // DRAM offset wraps
    d = zero_desc(); d.dram = 32'hFFFF_F800; d.xstride = 32; d.ysize = 128; d.xsize = 8;
    run(d, 1, "wrap");
    check("wrap c1 dram", got_q.size() == 2 ? 128'(got_q[1][57:26]) : 128'hx, 128'd0);

    // ysize == 0 with data
    d = zero_desc(); d.xsize = 4; d.pop_prev = 1; d.push_prev = 1; d.ypad1 = 3;
    run(d, 0, "ysize0");

    // Reset in the middle of a split tile
    @(negedge clock);
    drive_desc(split);
    io_desc_valid = 1'b1;
    io_inst_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    io_desc_valid = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midreset valid", 128'(io_inst_valid), 128'd0);
    check("midreset inst", io_inst, 128'd0);
    check("midreset desc_ready", 128'(io_desc_ready), 128'd1);
    check("midreset busy", 128'(io_busy), 128'd0);
    @(negedge clock);
    reset_n = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clock);
      if (io_inst_valid !== 1'b0) stray++;
    end
    check("post-reset stray insts", 128'(stray), 128'd0);

    // Randomized descriptors
    for (int i = 0; i < 25; i++) begin
      d.id = 3'($urandom); d.sram = 16'($urandom); d.dram = $urandom;
      d.ysize = 16'($urandom_range(0, 300));
      d.xsize = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      d.xstride = 16'($urandom);
      d.ypad0 = 4'($urandom); d.ypad1 = 4'($urandom);
      d.xpad0 = 4'($urandom); d.xpad1 = 4'($urandom);
      d.pop_prev = 1'($urandom); d.pop_next = 1'($urandom);
      d.push_prev = 1'($urandom); d.push_next = 1'($urandom);
      run(d, 1'($urandom), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
